line_decoder_seq: RTL and testbench

- Parametrised, registered successor to the team's 3-to-8 enable-gated line decoder: SEL_W-bit select to 2**SEL_W one-hot lines.
- Two modes:
  - Direct: registered decode of Sel.
  - Scan: FSM-driven auto-sweep through every line, each line held for a programmable dwell.
- Drives row/column strobes and chip-selects in display and test-pattern logic.

---
 rtl/line_decoder_pkg.sv | 33 +++
 rtl/line_decoder_core.sv | 32 +++
 rtl/line_decoder_seq.sv | 178 +++++++++++++++++
 tb/tb_line_decoder_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/line_decoder_pkg.sv
//------------------------------------------------------------------------------
// Module   : line_decoder_pkg
// Brief    : Shared types, mode constants and the line-mapping helper for the
//            line_decoder_seq block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package line_decoder_pkg;

  // Controller states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Map a select value onto a line index. With reversed set, the all-ones
  // select lands on line 0 (the mapping of the original 3-to-8 decoder).
  function automatic logic [31:0] map_idx(input logic [31:0] sel,
                                          input int          sel_w,
                                          input logic        reversed);
    logic [31:0] last;
    last = (32'd1 << sel_w) - 32'd1;
    return reversed ? (last - sel) : sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_decoder_core.sv
//------------------------------------------------------------------------------
// Module   : line_decoder_core
// Brief    : Purely combinational enable-gated SEL_W-to-2**SEL_W line decoder.
//            Output is all-zero when disabled, otherwise exactly one-hot.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_decoder_core
  import line_decoder_pkg::*;
#(
  parameter  int SEL_W    = 3,
  parameter  int REVERSED = 1,
  localparam int OUT_W    = 2 ** SEL_W
) (
  input  logic             Enable,
  input  logic [SEL_W-1:0] Sel,
  output logic [OUT_W-1:0] Line
);

  logic [SEL_W-1:0] mapped;

  assign mapped = SEL_W'(map_idx(32'(Sel), SEL_W, (REVERSED != 0)));

  // One comparator per line; at most one can match, so the result is one-hot
  for (genvar i = 0; i < OUT_W; i++) begin : g_line
    assign Line[i] = Enable && (mapped == SEL_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/line_decoder_seq.sv
//------------------------------------------------------------------------------
// Module   : line_decoder_seq
// Brief    : Registered line decoder with direct mode and an FSM-driven scan
//            mode that sweeps every line with a programmable dwell.
//            Optional build macro LINE_DECODER_SCAN_LOOP_EN: when defined, a
//            scan pass that ends with Mode=1 and Enable=1 pulses Done and
//            continues into the next pass without a gap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_decoder_seq
  import line_decoder_pkg::*;
#(
  parameter  int SEL_W    = 3,
  parameter  int REVERSED = 1,
  parameter  int DWELL_W  = 4,
  localparam int OUT_W    = 2 ** SEL_W
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Enable,
  input  logic               Mode,
  input  logic [SEL_W-1:0]   Sel,
  input  logic               Start,
  input  logic [DWELL_W-1:0] Dwell,
  output logic [OUT_W-1:0]   F,
  output logic               Busy,
  output logic               Done
);

  localparam logic [SEL_W-1:0] LINES_LAST = SEL_W'(OUT_W - 1);

  state_t               state;
  state_t               state_nxt;
  logic [SEL_W-1:0]     idx;
  logic [SEL_W-1:0]     idx_nxt;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [DWELL_W-1:0]   dwell_cnt_nxt;
  logic [DWELL_W-1:0]   dwell_cap;
  logic [DWELL_W-1:0]   dwell_cap_nxt;
  logic [SEL_W-1:0]     lines_left;
  logic [SEL_W-1:0]     lines_left_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 core_en;
  logic [SEL_W-1:0]     core_sel;
  logic [OUT_W-1:0]     core_line;
  logic                 pass_end;
  logic                 loop_cont;

  // Last active cycle of a pass: running, dwell exhausted, no lines left
  assign pass_end = (state == SCAN) && Enable &&
                    (dwell_cnt == '0) && (lines_left == '0);

`ifdef LINE_DECODER_SCAN_LOOP_EN
  assign loop_cont = (Mode == MODE_SCAN);
`else
  assign loop_cont = 1'b0;
`endif

  line_decoder_core #(
    .SEL_W    (SEL_W),
    .REVERSED (REVERSED)
  ) u_core (
    .Enable (core_en),
    .Sel    (core_sel),
    .Line   (core_line)
  );

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if ((Mode == MODE_SCAN) && Start && Enable) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (pass_end && !loop_cont) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and counter next values; F comes from the decoder so it can only
  // ever be zero or one-hot
  always_comb begin
    idx_nxt        = idx;
    dwell_cnt_nxt  = dwell_cnt;
    dwell_cap_nxt  = dwell_cap;
    lines_left_nxt = lines_left;
    busy_nxt       = Busy;
    done_nxt       = 1'b0;
    core_en        = 1'b0;
    core_sel       = Sel;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (Mode == MODE_DIRECT) begin
          core_en = Enable;
        end else if (Start && Enable) begin
          core_en        = 1'b1;
          idx_nxt        = Sel;
          dwell_cnt_nxt  = Dwell;
          dwell_cap_nxt  = Dwell;
          lines_left_nxt = LINES_LAST;
          busy_nxt       = 1'b1;
        end
      end
      SCAN: begin
        if (Enable) begin
          if (dwell_cnt != '0) begin
            // Hold (or re-show after a pause) the current line
            dwell_cnt_nxt = dwell_cnt - DWELL_W'(1);
            core_en       = 1'b1;
            core_sel      = idx;
          end else if ((lines_left != '0) || loop_cont) begin
            // After the last line, idx+1 wraps back onto the start select,
            // so a looping pass restarts where the first one began
            idx_nxt        = idx + SEL_W'(1);
            dwell_cnt_nxt  = dwell_cap;
            lines_left_nxt = (lines_left != '0) ? (lines_left - SEL_W'(1)) : LINES_LAST;
            core_en        = 1'b1;
            core_sel       = idx + SEL_W'(1);
            done_nxt       = (lines_left == '0);
          end else begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end
        end
      end
      FINISH: begin
        busy_nxt = 1'b0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      F          <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      idx        <= '0;
      dwell_cnt  <= '0;
      dwell_cap  <= '0;
      lines_left <= '0;
    end else begin
      F          <= core_line;
      Busy       <= busy_nxt;
      Done       <= done_nxt;
      idx        <= idx_nxt;
      dwell_cnt  <= dwell_cnt_nxt;
      dwell_cap  <= dwell_cap_nxt;
      lines_left <= lines_left_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_decoder_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_line_decoder_seq
// Brief    : Scoreboard bench for line_decoder_seq. Stimulus queues the
//            expected registered response; a monitor compares each cycle.
//            Loop-mode vectors are compiled in with LINE_DECODER_SCAN_LOOP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       mode;
  logic [2:0] sel;
  logic       start;
  logic [3:0] dwell;
  logic [7:0] f;
  logic       busy;
  logic       done;
  logic [7:0] f_nr;
  logic       busy_nr;
  logic       done_nr;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  f;
    logic        busy;
    logic        done;
    bit          chk_nr;
    logic [7:0]  f_nr;
    string       nm;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  line_decoder_seq #(.SEL_W(3), .REVERSED(1), .DWELL_W(4)) dut (
    .Clock(clk), .Reset_n(rst_n), .Enable(enable), .Mode(mode), .Sel(sel),
    .Start(start), .Dwell(dwell), .F(f), .Busy(busy), .Done(done)
  );

  line_decoder_seq #(.SEL_W(3), .REVERSED(0), .DWELL_W(4)) dut_nr (
    .Clock(clk), .Reset_n(rst_n), .Enable(enable), .Mode(mode), .Sel(sel),
    .Start(start), .Dwell(dwell), .F(f_nr), .Busy(busy_nr), .Done(done_nr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each cycle, compare the registered outputs against queued entries
  always @(posedge clk) begin
    #1;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc) begin
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", mon_e.nm, mon_e.cyc, cyc);
      end else if ({f, busy, done} !== {mon_e.f, mon_e.busy, mon_e.done} ||
                   (mon_e.chk_nr && (f_nr !== mon_e.f_nr))) begin
        $display("FAIL %s @%0d: got F=%h Busy=%b Done=%b F_nr=%h, want F=%h Busy=%b Done=%b F_nr=%h",
                 mon_e.nm, cyc, f, busy, done, f_nr, mon_e.f, mon_e.busy, mon_e.done, mon_e.f_nr);
      end else begin
        n_pass++;
      end
    end
  end

  // Drive one cycle of inputs and queue the response expected after the edge
  task automatic drive(input logic en, input logic md, input logic [2:0] s,
                       input logic st, input logic [3:0] dw,
                       input logic [7:0] ef, input logic eb, input logic ed,
                       input bit cnr, input logic [7:0] efnr, input string nm);
    exp_t e;
    @(negedge clk);
    enable = en; mode = md; sel = s; start = st; dwell = dw;
    e.cyc = cyc + 1; e.f = ef; e.busy = eb; e.done = ed;
    e.chk_nr = cnr; e.f_nr = efnr; e.nm = nm;
    sbq.push_back(e);
  endtask

  // Immediate comparison for checks that are not tied to a clock edge
  task automatic check_now(input string nm, input logic [7:0] ef,
                           input logic eb, input logic ed);
    n_checks++;
    if ({f, busy, done} !== {ef, eb, ed})
      $display("FAIL %s: got F=%h Busy=%b Done=%b, want F=%h Busy=%b Done=%b",
               nm, f, busy, done, ef, eb, ed);
    else
      n_pass++;
  endtask

  logic [7:0] scan_seq  [16] = '{8'h02, 8'h02, 8'h01, 8'h01, 8'h80, 8'h80, 8'h40, 8'h40,
                                 8'h20, 8'h20, 8'h10, 8'h10, 8'h08, 8'h08, 8'h04, 8'h04};
  logic [7:0] pause_seq [27] = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80,
                                 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h40,
                                 8'h20, 8'h20, 8'h20, 8'h10, 8'h10, 8'h10,
                                 8'h08, 8'h08, 8'h08, 8'h04, 8'h04, 8'h04};
  logic [7:0] sweep_seq [8]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; sel = 3'd0; start = 1'b0; dwell = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct mode, both line mappings
    drive(1, 0, 3'd7, 0, 0, 8'h01, 0, 0, 1, 8'h80, "direct_sel7");
    drive(1, 0, 3'd0, 0, 0, 8'h80, 0, 0, 1, 8'h01, "direct_sel0");
    drive(1, 0, 3'd2, 0, 0, 8'h20, 0, 0, 1, 8'h04, "direct_sel2");
    drive(0, 0, 3'd2, 0, 0, 8'h00, 0, 0, 1, 8'h00, "direct_disabled");
    drive(1, 1, 3'd3, 0, 0, 8'h00, 0, 0, 0, 8'h00, "idle_scan_no_start");

    // Scan Sel=6 Dwell=1; Mode/Sel/Dwell churn and a repeated Start are ignored
    drive(1, 1, 3'd6, 1, 4'd1, scan_seq[0], 1, 0, 0, 8'h00, "scan_start");
    for (int k = 1; k < 16; k++)
      drive(1, 0, 3'(k * 3), (k == 5), 4'(k), scan_seq[k], 1, 0, 0, 8'h00, "scan_line");
    drive(1, 0, 3'd0, 0, 0, 8'h00, 0, 1, 0, 8'h00, "scan_done");
    drive(1, 1, 3'd6, 1, 4'd1, 8'h00, 0, 0, 0, 8'h00, "start_in_finish");
    drive(0, 1, 3'd6, 0, 0, 8'h00, 0, 0, 0, 8'h00, "scan_idle_after");

    // Pause for three cycles during line 40 with Dwell=2
    drive(1, 1, 3'd6, 1, 4'd2, pause_seq[0], 1, 0, 0, 8'h00, "pause_start");
    for (int k = 1; k < 27; k++)
      drive(!(k >= 11 && k <= 13), 0, 3'd1, 0, 4'd9, pause_seq[k], 1, 0, 0, 8'h00, "pause_line");
    drive(1, 0, 3'd0, 0, 0, 8'h00, 0, 1, 0, 8'h00, "pause_done");
    drive(0, 0, 3'd0, 0, 0, 8'h00, 0, 0, 0, 8'h00, "pause_finish");

    // Asynchronous reset in the middle of a scan, away from any clock edge
    drive(1, 1, 3'd6, 1, 4'd1, 8'h02, 1, 0, 0, 8'h00, "prereset_start");
    drive(1, 0, 3'd0, 0, 0, 8'h02, 1, 0, 0, 8'h00, "prereset_hold");
    drive(1, 0, 3'd0, 0, 0, 8'h01, 1, 0, 0, 8'h00, "prereset_next");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 8'h00, 1'b0, 1'b0);
    enable = 1'b0; mode = 1'b0; start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 3'd2, 0, 0, 8'h00, 0, 0, 0, 8'h00, "post_reset_idle");

    // Dwell=0 sweep from Sel=0: one line per cycle
    drive(1, 1, 3'd0, 1, 4'd0, sweep_seq[0], 1, 0, 0, 8'h00, "sweep_start");
    for (int k = 1; k < 8; k++)
      drive(1, 0, 3'd5, 0, 4'd3, sweep_seq[k], 1, 0, 0, 8'h00, "sweep_line");
    drive(1, 0, 3'd0, 0, 0, 8'h00, 0, 1, 0, 8'h00, "sweep_done");
    drive(0, 0, 3'd0, 0, 0, 8'h00, 0, 0, 0, 8'h00, "sweep_finish");

`ifdef LINE_DECODER_SCAN_LOOP_EN
    // Looping: Done every 8 cycles with no gap, then Mode cleared mid-pass
    drive(1, 1, 3'd0, 1, 4'd0, sweep_seq[0], 1, 0, 0, 8'h00, "loop_start");
    for (int k = 1; k < 8; k++)
      drive(1, 1, 3'd0, 0, 0, sweep_seq[k], 1, 0, 0, 8'h00, "loop_p1");
    for (int k = 0; k < 8; k++)
      drive(1, 1, 3'd0, 0, 0, sweep_seq[k], 1, (k == 0), 0, 8'h00, "loop_p2");
    for (int k = 0; k < 8; k++)
      drive(1, (k < 4), 3'd0, 0, 0, sweep_seq[k], 1, (k == 0), 0, 8'h00, "loop_p3");
    drive(1, 0, 3'd0, 0, 0, 8'h00, 0, 1, 0, 8'h00, "loop_done");
    drive(0, 0, 3'd0, 0, 0, 8'h00, 0, 0, 0, 8'h00, "loop_finish");
`endif

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sbq.size() != 0)
      $display("FAIL scoreboard_drained: %0d entries left, want 0", sbq.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
